game_controller: RTL and testbench

- Top-level game sequencer for the whack-a-box game.
- Owns the lobby → play → game-over flow and picks each target box from the LFSR value.
- Drives the VGA screen select (`level_select`) and the audio triggers (`play_sound`, `lobby_sound`).
- Scores hits reported by the sensor decoder (`box_address`) and runs the game countdown and per-target hit window.
- Sits between the LFSR, the sensor decoder, the VGA fill block and the audio block.

---
 rtl/game_pkg.sv | 33 +++
 rtl/game_tick_gen.sv | 41 ++++
 rtl/game_controller.sv | 185 ++++++++++++++++++
 tb/tb_game_controller.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the whack-a-box game sequencer.
// Also holds the target-box selection rule used by the PICK state.
package game_pkg;

    typedef enum logic [1:0] {
        LOBBY     = 2'd0,
        PICK      = 2'd1,
        WAIT      = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    localparam logic [2:0] LEVEL_LOBBY    = 3'd0;
    localparam logic [2:0] LEVEL_GAMEOVER = 3'd7;
    localparam logic [7:0] SCORE_MAX      = 8'd255;

    // Folds a raw 3-bit random value onto 1..n and never repeats the previous target.
    function automatic logic [2:0] pick_box(input logic [2:0] raw,
                                            input logic [2:0] prev,
                                            input logic [2:0] n);
        logic [2:0] cand;
        cand = raw;
        if (cand == 3'd0) begin
            cand = 3'd1;
        end else if (cand > n) begin
            cand = cand - n;
        end
        if (cand == prev) begin
            cand = (cand >= n) ? 3'd1 : cand + 3'd1;
        end
        return cand;
    endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Free-running cycle counter that emits a one-cycle tick every CYCLES enabled cycles.
module game_tick_gen #(
    parameter int unsigned CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_controller.sv
// Whack-a-box game sequencer: lobby, target picking, hit scoring, countdown and game over.
// Every output is a flop whose next value is derived from the next state.
module game_controller
    import game_pkg::*;
#(
    parameter int unsigned NUM_BOXES    = 6,
    parameter int unsigned SEC_CYCLES   = 50_000_000,
    parameter int unsigned GAME_SECONDS = 60,
    parameter int unsigned WINDOW_INIT  = 100_000_000,
    parameter int unsigned WINDOW_STEP  = 10_000_000,
    parameter int unsigned WINDOW_MIN   = 30_000_000,
    parameter int unsigned LEVEL_HITS   = 5,
    parameter int unsigned SOUND_CYCLES = 25_000_000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] lfsr_value,
    input  logic [2:0] box_address,
    output logic [2:0] level_select,
    output logic       lobby_sound,
    output logic       play_sound,
    output logic [7:0] score,
    output logic [5:0] game_timer,
    output logic [1:0] difficulty,
    output logic       game_over
);

    localparam int unsigned WIN_W = $clog2(WINDOW_INIT + 1);
    localparam int unsigned SND_W = $clog2(SOUND_CYCLES + 1);
    localparam int unsigned HIT_W = $clog2(LEVEL_HITS + 1);

    state_t           state_q, state_d;
    logic [2:0]       box_s1_q, box_s_q, box_p_q;
    logic [2:0]       target_q, target_d;
    logic [WIN_W-1:0] window_q, window_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [SND_W-1:0] snd_cnt_q, snd_cnt_d;
    logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [7:0]       score_q, score_d;
    logic [5:0]       timer_q, timer_d;
    logic [1:0]       diff_q, diff_d;
    logic [2:0]       level_q, level_d;
    logic             lobby_q, lobby_d;
    logic             play_q, play_d;
    logic             game_over_q, game_over_d;

    logic in_game;
    logic hit_event;
    logic sec_tick;

    assign in_game   = (state_q == PICK) || (state_q == WAIT);
    assign hit_event = (box_s_q != 3'd0) && (box_s_q != box_p_q);

    game_tick_gen #(.CYCLES(SEC_CYCLES)) u_sec_tick (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .en    (in_game && (timer_q != 6'd0)),
        .clr   (state_q == LOBBY),
        .tick  (sec_tick)
    );

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        window_d  = window_q;
        win_cnt_d = win_cnt_q;
        hit_cnt_d = hit_cnt_q;
        score_d   = score_q;
        timer_d   = timer_q;
        diff_d    = diff_q;
        snd_cnt_d = snd_cnt_q;
        if (snd_cnt_q != '0) snd_cnt_d = snd_cnt_q - SND_W'(1);
        if (sec_tick) timer_d = timer_q - 6'd1;

        case (state_q)
            LOBBY: begin
                if (start) begin
                    score_d   = '0;
                    diff_d    = '0;
                    hit_cnt_d = '0;
                    timer_d   = 6'(GAME_SECONDS);
                    window_d  = WIN_W'(WINDOW_INIT);
                    state_d   = PICK;
                end
            end
            PICK: begin
                target_d  = pick_box(lfsr_value, target_q, 3'(NUM_BOXES));
                win_cnt_d = window_q;
                state_d   = WAIT;
            end
            WAIT: begin
                if (hit_event && (box_s_q == target_q)) begin
                    if (score_q != SCORE_MAX) score_d = score_q + 8'd1;
                    snd_cnt_d = SND_W'(SOUND_CYCLES);
                    if (hit_cnt_q + HIT_W'(1) == HIT_W'(LEVEL_HITS)) begin
                        hit_cnt_d = '0;
                        if (32'(window_q) >= WINDOW_MIN + WINDOW_STEP) begin
                            window_d = window_q - WIN_W'(WINDOW_STEP);
                        end else begin
                            window_d = WIN_W'(WINDOW_MIN);
                        end
                        if (diff_q != 2'd3) diff_d = diff_q + 2'd1;
                    end else begin
                        hit_cnt_d = hit_cnt_q + HIT_W'(1);
                    end
                    state_d = PICK;
                end else begin
                    // A wrong strike costs a point but leaves the window running.
                    if (hit_event && (score_q != 8'd0)) score_d = score_q - 8'd1;
                    if (win_cnt_q <= WIN_W'(1)) begin
                        state_d = PICK;
                    end else begin
                        win_cnt_d = win_cnt_q - WIN_W'(1);
                    end
                end
            end
            GAME_OVER: begin
                if (start) state_d = LOBBY;
            end
            default: state_d = LOBBY;
        endcase

        // Scoring above has already happened when the countdown ends the game.
        if (in_game && (timer_q == 6'd0)) state_d = GAME_OVER;
        if (state_d == LOBBY) snd_cnt_d = '0;

        case (state_d)
            LOBBY:     level_d = LEVEL_LOBBY;
            GAME_OVER: level_d = LEVEL_GAMEOVER;
            WAIT:      level_d = target_d;
            default:   level_d = level_q;
        endcase
        lobby_d     = (state_d == LOBBY);
        game_over_d = (state_d == GAME_OVER);
        play_d      = (snd_cnt_d != '0);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= LOBBY;
            box_s1_q    <= 3'd0;
            box_s_q     <= 3'd0;
            box_p_q     <= 3'd0;
            target_q    <= 3'd0;
            window_q    <= WIN_W'(WINDOW_INIT);
            win_cnt_q   <= '0;
            snd_cnt_q   <= '0;
            hit_cnt_q   <= '0;
            score_q     <= 8'd0;
            timer_q     <= 6'(GAME_SECONDS);
            diff_q      <= 2'd0;
            level_q     <= LEVEL_LOBBY;
            lobby_q     <= 1'b1;
            play_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            box_s1_q    <= box_address;
            box_s_q     <= box_s1_q;
            box_p_q     <= box_s_q;
            target_q    <= target_d;
            window_q    <= window_d;
            win_cnt_q   <= win_cnt_d;
            snd_cnt_q   <= snd_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
            score_q     <= score_d;
            timer_q     <= timer_d;
            diff_q      <= diff_d;
            level_q     <= level_d;
            lobby_q     <= lobby_d;
            play_q      <= play_d;
            game_over_q <= game_over_d;
        end
    end

    assign level_select = level_q;
    assign lobby_sound  = lobby_q;
    assign play_sound   = play_q;
    assign score        = score_q;
    assign game_timer   = timer_q;
    assign difficulty   = diff_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with short timing parameters and an expected-value queue.
module tb_game_controller;

    localparam int NB = 6;
    localparam int SEC = 20;
    localparam int GS = 3;
    localparam int WI = 30;
    localparam int WS = 10;
    localparam int WM = 10;
    localparam int LH = 2;
    localparam int SC = 5;
    localparam int W = 16;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [2:0] lfsr;
    logic [2:0] box;
    logic [2:0] level_select;
    logic       lobby_sound;
    logic       play_sound;
    logic [7:0] score;
    logic [5:0] game_timer;
    logic [1:0] difficulty;
    logic       game_over;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int prev_t;
    int target;
    int n;
    int pcnt;

    always #5 clk = ~clk;

    game_controller #(
        .NUM_BOXES(NB), .SEC_CYCLES(SEC), .GAME_SECONDS(GS), .WINDOW_INIT(WI),
        .WINDOW_STEP(WS), .WINDOW_MIN(WM), .LEVEL_HITS(LH), .SOUND_CYCLES(SC)
    ) dut (
        .CLOCK_50     (clk),
        .resetn       (resetn),
        .start        (start),
        .lfsr_value   (lfsr),
        .box_address  (box),
        .level_select (level_select),
        .lobby_sound  (lobby_sound),
        .play_sound   (play_sound),
        .score        (score),
        .game_timer   (game_timer),
        .difficulty   (difficulty),
        .game_over    (game_over)
    );

    function automatic int model_pick(input int raw, input int prev);
        int c;
        c = raw;
        if (c == 0) c = 1;
        else if (c > NB) c = c - NB;
        if (c == prev) c = (c % NB) + 1;
        return c;
    endfunction

    task automatic step(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic expect_v(input int v);
        exp_q.push_back(W'(v));
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs);
        logic [W-1:0] exp_v;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %0d with no expected value queued", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0; start = 1'b0; lfsr = 3'd7; box = 3'd0;
        step(2);
        expect_v(0); expect_v(1); expect_v(0); expect_v(0); expect_v(GS); expect_v(0); expect_v(0);
        check("rst_level", 16'(level_select));
        check("rst_lobby", 16'(lobby_sound));
        check("rst_play", 16'(play_sound));
        check("rst_score", 16'(score));
        check("rst_timer", 16'(game_timer));
        check("rst_diff", 16'(difficulty));
        check("rst_gameover", 16'(game_over));
        resetn = 1'b1;
        step(1);

        // Game 1: picking, window length, a held correct strike, game over.
        prev_t = 0;
        pulse_start();
        expect_v(0); expect_v(0);
        check("pick_cycle_level", 16'(level_select));
        check("lobby_off", 16'(lobby_sound));
        step(1);
        target = model_pick(7, prev_t); prev_t = target;
        expect_v(target);
        check("first_target", 16'(level_select));
        lfsr = 3'd0;
        n = 0;
        while (level_select == target[2:0] && n < 200) begin step(1); n++; end
        expect_v(WI + 1);
        check("window_init_len", 16'(n));
        target = model_pick(0, prev_t); prev_t = target;
        expect_v(target);
        check("lfsr_zero_target", 16'(level_select));
        box = target[2:0];
        n = 0;
        while (score == 8'd0 && n < 20) begin step(1); n++; end
        expect_v(3); expect_v(1); expect_v(prev_t); expect_v(1);
        check("hit_latency", 16'(n));
        check("hit_score", 16'(score));
        check("hit_old_level", 16'(level_select));
        check("hit_sound_on", 16'(play_sound));
        pcnt = 1;
        step(1);
        target = model_pick(0, prev_t); prev_t = target;
        expect_v(target);
        check("next_target", 16'(level_select));
        if (play_sound) pcnt++;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (!play_sound) break;
            pcnt++;
        end
        expect_v(SC);
        check("sound_len", 16'(pcnt));
        step(42);
        box = 3'd0;
        step(1);
        expect_v(1); expect_v(1); expect_v(7); expect_v(0); expect_v(0);
        check("held_once_score", 16'(score));
        check("g1_over", 16'(game_over));
        check("g1_over_level", 16'(level_select));
        check("g1_over_lobby", 16'(lobby_sound));
        check("g1_over_timer", 16'(game_timer));
        pulse_start();
        expect_v(0); expect_v(1); expect_v(0); expect_v(1);
        check("lobby_level", 16'(level_select));
        check("lobby_sound", 16'(lobby_sound));
        check("lobby_gameover", 16'(game_over));
        check("lobby_score_held", 16'(score));

        // Game 2: wrong strike at zero, difficulty step, shorter window, reset mid-WAIT.
        lfsr = 3'd3;
        pulse_start();
        expect_v(0); expect_v(GS); expect_v(0);
        check("g2_score_clear", 16'(score));
        check("g2_timer_load", 16'(game_timer));
        check("g2_diff_clear", 16'(difficulty));
        step(1);
        target = model_pick(3, prev_t); prev_t = target;
        expect_v(target);
        check("g2_target", 16'(level_select));
        box = 3'd5;
        step(3);
        expect_v(0);
        check("wrong_at_zero", 16'(score));
        box = 3'd0;
        step(2);
        box = target[2:0];
        step(3);
        expect_v(1);
        check("g2_hit1", 16'(score));
        step(1);
        target = model_pick(3, prev_t); prev_t = target;
        expect_v(target);
        check("g2_target2", 16'(level_select));
        box = target[2:0];
        step(3);
        expect_v(2); expect_v(1);
        check("g2_hit2", 16'(score));
        check("g2_diff1", 16'(difficulty));
        step(1);
        target = model_pick(3, prev_t); prev_t = target;
        expect_v(target);
        check("g2_target3", 16'(level_select));
        n = 0;
        while (level_select == target[2:0] && n < 200) begin step(1); n++; end
        expect_v(WI - WS + 1);
        check("window_step_len", 16'(n));
        target = model_pick(3, prev_t); prev_t = target;
        expect_v(target);
        check("g2_target4", 16'(level_select));
        box = 3'd0;
        step(2);
        box = target[2:0];
        step(3);
        expect_v(3);
        check("g2_hit3", 16'(score));
        step(1);
        target = model_pick(3, prev_t); prev_t = target;
        expect_v(target);
        check("g2_target5", 16'(level_select));
        box = target[2:0];
        step(3);
        expect_v(4); expect_v(2);
        check("g2_hit4", 16'(score));
        check("g2_diff2", 16'(difficulty));
        step(1);
        target = model_pick(3, prev_t); prev_t = target;
        expect_v(target);
        check("g2_target6", 16'(level_select));
        resetn = 1'b0;
        #1;
        expect_v(0); expect_v(1); expect_v(0); expect_v(GS); expect_v(0); expect_v(0);
        check("async_rst_level", 16'(level_select));
        check("async_rst_lobby", 16'(lobby_sound));
        check("async_rst_score", 16'(score));
        check("async_rst_timer", 16'(game_timer));
        check("async_rst_diff", 16'(difficulty));
        check("async_rst_play", 16'(play_sound));
        prev_t = 0;
        box = 3'd0;
        @(negedge clk);
        resetn = 1'b1;
        step(1);

        // Game 3: idle countdown to game over.
        lfsr = 3'd5;
        pulse_start();
        step(1);
        target = model_pick(5, prev_t); prev_t = target;
        expect_v(target);
        check("g3_target", 16'(level_select));
        step(SEC - 2);
        expect_v(GS);
        check("timer_before_tick", 16'(game_timer));
        step(1);
        expect_v(GS - 1);
        check("timer_tick1", 16'(game_timer));
        step(SEC);
        expect_v(GS - 2);
        check("timer_tick2", 16'(game_timer));
        step(SEC);
        target = model_pick(5, prev_t); prev_t = target;
        expect_v(0); expect_v(0); expect_v(target);
        check("timer_zero", 16'(game_timer));
        check("not_over_yet", 16'(game_over));
        check("g3_target2", 16'(level_select));
        step(1);
        expect_v(1); expect_v(7); expect_v(0); expect_v(0);
        check("g3_over", 16'(game_over));
        check("g3_over_level", 16'(level_select));
        check("g3_over_lobby", 16'(lobby_sound));
        check("g3_score", 16'(score));
        pulse_start();
        expect_v(0); expect_v(1); expect_v(0);
        check("g3_lobby_level", 16'(level_select));
        check("g3_lobby_sound", 16'(lobby_sound));
        check("g3_lobby_gameover", 16'(game_over));

        // Game 4: a correct hit scored in the same cycle the countdown ends the game.
        pulse_start();
        expect_v(0); expect_v(GS);
        check("g4_score", 16'(score));
        check("g4_timer", 16'(game_timer));
        step(1);
        target = model_pick(5, prev_t); prev_t = target;
        expect_v(target);
        check("g4_target", 16'(level_select));
        step(3 * SEC - 3);
        target = model_pick(5, prev_t); prev_t = target;
        expect_v(target);
        check("g4_target2", 16'(level_select));
        box = target[2:0];
        step(2);
        expect_v(0); expect_v(0); expect_v(0);
        check("g4_pre_score", 16'(score));
        check("g4_pre_timer", 16'(game_timer));
        check("g4_pre_over", 16'(game_over));
        step(1);
        expect_v(1); expect_v(1); expect_v(7);
        check("simul_score", 16'(score));
        check("simul_over", 16'(game_over));
        check("simul_level", 16'(level_select));
        box = 3'd0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
